// File: rtl/gate_bank_tester.sv
// Stimulus-and-check engine for the seven-gate logic bank (AND, OR, NOT a, NAND, NOR, XOR, XNOR).
// Sweeps a/b through 00,01,10,11 LOOPS times, sampling y_in after each settle window.
module gate_bank_tester #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned LOOPS         = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] fail_mask,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t     state, state_d;
    logic [7:0] loop_cnt, loop_d;
    logic [7:0] settle_cnt, settle_d;
    logic       a_d, b_d, busy_d, done_d, pass_d;
    logic [6:0] fail_mask_d;
    logic [7:0] err_count_d;

    logic [6:0] expected;
    logic [6:0] mismatch;
    logic [8:0] err_sum;

    function automatic logic [3:0] popcount7(input logic [6:0] v);
        logic [3:0] n;
        n = '0;
        for (int unsigned i = 0; i < 7; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    assign expected = {~(a_out ^ b_out), a_out ^ b_out, ~(a_out | b_out),
                       ~(a_out & b_out), ~a_out, a_out | b_out, a_out & b_out};
    assign mismatch = y_in ^ expected;
    assign err_sum  = {1'b0, err_count} + {5'b00000, popcount7(mismatch)};

    // {a_out,b_out} doubles as the vector index while a run is active.
    always_comb begin
        state_d     = state;
        loop_d      = loop_cnt;
        settle_d    = settle_cnt;
        a_d         = a_out;
        b_d         = b_out;
        busy_d      = busy;
        done_d      = 1'b0;
        pass_d      = pass;
        fail_mask_d = fail_mask;
        err_count_d = err_count;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d     = SETTLE;
                    fail_mask_d = '0;
                    err_count_d = '0;
                    pass_d      = 1'b0;
                    loop_d      = '0;
                    settle_d    = '0;
                    a_d         = 1'b0;
                    b_d         = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            SETTLE: begin
                if (settle_cnt == 8'(SETTLE_CYCLES - 1)) begin
                    state_d  = SAMPLE;
                    settle_d = '0;
                end else begin
                    settle_d = settle_cnt + 8'd1;
                end
            end
            SAMPLE: begin
                fail_mask_d = fail_mask | mismatch;
                err_count_d = err_sum[8] ? 8'hFF : err_sum[7:0];
                if ({a_out, b_out} == 2'b11 && loop_cnt == 8'(LOOPS - 1)) begin
                    state_d = DONE;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (fail_mask_d == '0);
                end else begin
                    state_d    = SETTLE;
                    settle_d   = '0;
                    {a_d, b_d} = 2'({a_out, b_out} + 2'd1);
                    if ({a_out, b_out} == 2'b11) begin
                        loop_d = loop_cnt + 8'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            loop_cnt   <= '0;
            settle_cnt <= '0;
            a_out      <= 1'b0;
            b_out      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_mask  <= '0;
            err_count  <= '0;
        end else begin
            state      <= state_d;
            loop_cnt   <= loop_d;
            settle_cnt <= settle_d;
            a_out      <= a_d;
            b_out      <= b_d;
            busy       <= busy_d;
            done       <= done_d;
            pass       <= pass_d;
            fail_mask  <= fail_mask_d;
            err_count  <= err_count_d;
        end
    end

endmodule

// File: tb/tb_gate_bank_tester.sv
// Directed bench for gate_bank_tester: three instances (LOOPS 1, 3, 40) each driving a
// behavioural gate bank with a selectable fault.
module tb_gate_bank_tester;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_v [3];
    logic [6:0] y_v     [3];
    logic       a_v     [3];
    logic       b_v     [3];
    logic       busy_v  [3];
    logic       done_v  [3];
    logic       pass_v  [3];
    logic [6:0] fm_v    [3];
    logic [7:0] ec_v    [3];
    int         mode_v  [3];

    int checks = 0;
    int errors = 0;

    // 0: healthy, 1: XOR stuck 0, 2: NOT stuck 1, 3: all outputs inverted
    function automatic logic [6:0] bank(input logic a, input logic b, input int mode);
        logic [6:0] good;
        good = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
        case (mode)
            1:       return good & ~7'h20;
            2:       return good | 7'h04;
            3:       return ~good;
            default: return good;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            y_v[i] = bank(a_v[i], b_v[i], mode_v[i]);
        end
    end

    gate_bank_tester u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .y_in(y_v[0]),
        .a_out(a_v[0]), .b_out(b_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .pass(pass_v[0]), .fail_mask(fm_v[0]), .err_count(ec_v[0])
    );

    gate_bank_tester #(.SETTLE_CYCLES(2), .LOOPS(3)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .y_in(y_v[1]),
        .a_out(a_v[1]), .b_out(b_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .pass(pass_v[1]), .fail_mask(fm_v[1]), .err_count(ec_v[1])
    );

    gate_bank_tester #(.SETTLE_CYCLES(2), .LOOPS(40)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .y_in(y_v[2]),
        .a_out(a_v[2]), .b_out(b_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .pass(pass_v[2]), .fail_mask(fm_v[2]), .err_count(ec_v[2])
    );

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle_zero(input int idx, input string tag);
        check({tag, "_a"},    a_v[idx],    0);
        check({tag, "_b"},    b_v[idx],    0);
        check({tag, "_busy"}, busy_v[idx], 0);
        check({tag, "_done"}, done_v[idx], 0);
        check({tag, "_pass"}, pass_v[idx], 0);
        check({tag, "_fm"},   fm_v[idx],   0);
        check({tag, "_ec"},   ec_v[idx],   0);
    endtask

    // Start at edge 0, then walk edges 1..n; done must appear only after edge n.
    // pulse_edge > 0 re-asserts start so it is sampled at that edge mid-run.
    task automatic run(input int idx, input int n, input int pulse_edge,
                       input int unsigned efm, input int unsigned eec, input int unsigned epass);
        start_v[idx] = 1'b1;
        @(posedge clk); #1;
        start_v[idx] = 1'b0;
        check("start_busy", busy_v[idx], 1);
        check("start_vec", {a_v[idx], b_v[idx]}, 0);
        check("start_pass_clr", pass_v[idx], 0);
        for (int e = 1; e <= n; e++) begin
            if (e == pulse_edge) start_v[idx] = 1'b1;
            @(posedge clk); #1;
            start_v[idx] = 1'b0;
            check("done_timing", done_v[idx], (e == n) ? 1 : 0);
            if (e < n) begin
                check("busy_run", busy_v[idx], 1);
                check("vec", {a_v[idx], b_v[idx]}, (e / 3) % 4);
            end
        end
        check("end_busy", busy_v[idx], 0);
        check("end_vec", {a_v[idx], b_v[idx]}, 0);
        check("end_pass", pass_v[idx], epass);
        check("end_fm", fm_v[idx], efm);
        check("end_ec", ec_v[idx], eec);
        @(posedge clk); #1;
        check("hold_done", done_v[idx], 0);
        check("hold_busy", busy_v[idx], 0);
        check("hold_pass", pass_v[idx], epass);
        check("hold_fm", fm_v[idx], efm);
        check("hold_ec", ec_v[idx], eec);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            mode_v[i]  = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle_zero(0, "rst0");
        check_idle_zero(1, "rst1");
        check_idle_zero(2, "rst2");

        // healthy bank, defaults
        run(0, 12, 0, 7'h00, 0, 1);

        // XOR stuck 0: ab=01 and 10 mismatch
        mode_v[0] = 1;
        run(0, 12, 0, 7'h20, 2, 0);

        // NOT stuck 1, three sweeps
        mode_v[1] = 2;
        run(1, 36, 0, 7'h04, 6, 0);

        // all inverted, 40 sweeps: 1120 mismatches saturate
        mode_v[2] = 3;
        run(2, 480, 0, 7'h7F, 255, 0);

        // start re-pulsed at edge 5 must be ignored
        mode_v[0] = 0;
        run(0, 12, 5, 7'h00, 0, 1);

        // reset at edge 5 after an inverted-bank sample has dirtied the results
        mode_v[0]  = 3;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk); #1;
        end
        check("pre_rst_fm", fm_v[0], 7'h7F);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_zero(0, "midrst");
        for (int e = 0; e < 20; e++) begin
            @(posedge clk); #1;
            check("no_done_after_rst", done_v[0], 0);
        end

        mode_v[0] = 0;
        run(0, 12, 0, 7'h00, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
